mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Parametrised N-port arbiter that merges the burst memory request ports (p1 program cache, p2 data cache, p3 video/DMA, and more) onto one SDRAM controller request port.
- Generalises the current fixed three-port p1/p2/p3 scheme in four ways: port count, address width, burst length, and arbitration mode (fixed priority or round-robin).
- Sits between the caches/DMA and the SDRAM controller inside the PVP top level.

Parameters:
- N_PORTS, 3, number of requester ports (2..8).
- ADDR_W, 32, request address width.
- DATA_W, 16, memory word width.
- BURST_LEN, 4, words per transaction (power of 2, 2..16); OFS_W = clog2(BURST_LEN).
- RR_MODE, 0, 0 = fixed priority (port 0 highest), 1 = round-robin.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous active-low reset.
- p_req  in  N_PORTS  per-port request, held until the port's last ready beat.
- p_wren  in  N_PORTS  per-port write (1) / read (0).
- p_address  in  N_PORTS*ADDR_W  packed burst base addresses, port i at [i*ADDR_W +: ADDR_W].
- p_to_mem  in  N_PORTS*DATA_W  packed write data, word for the current p_offset.
- p_ready  out  N_PORTS  per-port beat strobe; only the granted port is ever asserted.
- p_offset  out  OFS_W  beat word index, broadcast to all ports.
- from_mem  out  DATA_W  read data, broadcast to all ports.
- grant  out  N_PORTS  one-hot current owner; all zero when idle.
- busy  out  1  a transaction is in progress.
- ctrl_req  out  1  request to the controller.
- ctrl_wren  out  1  write/read to the controller.
- ctrl_address  out  ADDR_W  address to the controller.
- ctrl_to_mem  out  DATA_W  write data to the controller.
- ctrl_ready  in  1  controller beat strobe.
- ctrl_offset  in  OFS_W  controller beat index.
- ctrl_from_mem  in  DATA_W  controller read data.

Behaviour:
- Reset (asynchronous, reset=0):
  - state=IDLE; grant=0; busy=0; ctrl_req=0; ctrl_wren=0; ctrl_address=0; beat count=0.
  - RR pointer = N_PORTS-1, so port 0 is searched first.
  - Reset asserted mid-burst aborts immediately; no further p_ready is produced.
- FSM states: IDLE, ACTIVE, RELEASE.
- IDLE:
  - If any p_req is set, select the winner combinationally.
    - Fixed mode: lowest index wins.
    - RR mode: first requester found scanning from (ptr+1) mod N_PORTS upward, wrapping.
  - On the next edge: register grant (one-hot), ctrl_address/ctrl_wren from the winner, set ctrl_req=1 and busy=1, enter ACTIVE.
  - Latency: req to ctrl_req is 1 cycle.
- ACTIVE:
  - ctrl_req held at 1; address and wren stay frozen from the registered copy, even if the port changes its inputs.
  - ctrl_to_mem = p_to_mem of the granted port (combinational mux, zero latency).
  - p_ready[g] = ctrl_ready & grant[g] (combinational).
  - p_offset = ctrl_offset and from_mem = ctrl_from_mem at all times (pass-through).
  - Beats need not be consecutive.
  - Beat counter increments on each ctrl_ready.
  - On the edge where the counter is BURST_LEN-1 and ctrl_ready=1: ctrl_req<=0, counter<=0, RR ptr<=granted index, enter RELEASE.
- RELEASE:
  - One cycle; grant still held (so busy=1); no new arbitration. This gives the requester one cycle to drop p_req.
  - Next edge: grant<=0, busy<=0, enter IDLE.
  - Back-to-back transactions from the same port therefore have a 2-cycle gap (RELEASE + IDLE).
- Requester drops p_req during ACTIVE (protocol violation): ignored; the burst completes and the port receives all beats.
- ctrl_ready while IDLE or RELEASE: ignored; no p_ready asserted; counter unchanged.
- Simultaneous requests:
  - Fixed mode can starve high-index ports; this is intended.
  - RR mode guarantees each requester is granted within N_PORTS transactions.
- Counter width OFS_W; it wraps naturally at BURST_LEN.

Test Plan:
- Single read, port 1, address 0x0000_0100: ctrl_req rises 1 cycle after p_req, ctrl_address=0x100, ctrl_wren=0. 4 ctrl_ready beats with offsets 0..3 and data 0xA000..0xA003 → p_ready[1] pulses 4 times with matching from_mem, p_ready[0]=p_ready[2]=0, busy falls 2 cycles after the last beat.
- Write, port 2, p_to_mem tracking offset (0x1110+offset), beats with 1-cycle bubbles → ctrl_to_mem = 0x1110..0x1113 on each beat, ctrl_wren=1, exactly 4 p_ready[2] pulses.
- Fixed mode, all 3 ports requesting continuously → grant sequence 001,001,001…; port 2 is never granted.
- RR_MODE=1, all 3 ports requesting continuously → grant sequence 001,010,100,001. With only ports 0 and 2 requesting → 001,100,001.
- Reset pulled low after beat 2 of 4 → ctrl_req=0, grant=0, busy=0 immediately. After release with p_req[0]=1 → a fresh burst, counter starting at 0.
- Parameter sweep N_PORTS=8, BURST_LEN=8, RR_MODE=1, port 7 only → grant=8'h80, 8 beats with p_offset 0..7, ptr=7. A following port 0 request is granted next.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: merges N burst request ports onto a single SDRAM
// controller request port. A winner is picked in IDLE, owns the controller
// for BURST_LEN beats, then holds grant for one RELEASE cycle so it can drop
// its request before the next arbitration.
module mem_port_arbiter #(
  parameter int N_PORTS   = 3,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 16,
  parameter int BURST_LEN = 4,
  parameter int RR_MODE   = 0,
  localparam int OFS_W    = $clog2(BURST_LEN),
  localparam int IDX_W    = $clog2(N_PORTS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_PORTS-1:0]        p_req,
  input  logic [N_PORTS-1:0]        p_wren,
  input  logic [N_PORTS*ADDR_W-1:0] p_address,
  input  logic [N_PORTS*DATA_W-1:0] p_to_mem,
  output logic [N_PORTS-1:0]        p_ready,
  output logic [OFS_W-1:0]          p_offset,
  output logic [DATA_W-1:0]         from_mem,
  output logic [N_PORTS-1:0]        grant,
  output logic                      busy,
  output logic                      ctrl_req,
  output logic                      ctrl_wren,
  output logic [ADDR_W-1:0]         ctrl_address,
  output logic [DATA_W-1:0]         ctrl_to_mem,
  input  logic                      ctrl_ready,
  input  logic [OFS_W-1:0]          ctrl_offset,
  input  logic [DATA_W-1:0]         ctrl_from_mem
);

  typedef enum logic [1:0] {IDLE, ACTIVE, RELEASE} state_t;

  state_t               state_q, state_d;
  logic [N_PORTS-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]     gidx_q, gidx_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic                 req_q, req_d;
  logic                 wren_q, wren_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [OFS_W-1:0]     cnt_q, cnt_d;

  logic                 win_found;
  logic [IDX_W-1:0]     win_idx;
  logic                 win_wren;
  logic [ADDR_W-1:0]    win_addr;
  int                   scan_start, scan_dist, scan_best;

  // Winner search: smallest circular distance from the scan start.
  // Fixed mode scans from port 0, round-robin from the port after the last owner.
  always_comb begin
    win_found  = 1'b0;
    win_idx    = '0;
    win_wren   = 1'b0;
    win_addr   = '0;
    scan_start = 0;
    scan_dist  = 0;
    scan_best  = N_PORTS;
    if (RR_MODE != 0) begin
      scan_start = int'(ptr_q) + 1;
      if (scan_start >= N_PORTS) scan_start = 0;
    end
    for (int i = 0; i < N_PORTS; i++) begin
      scan_dist = i - scan_start;
      if (scan_dist < 0) scan_dist = scan_dist + N_PORTS;
      if (p_req[i] && (scan_dist < scan_best)) begin
        scan_best = scan_dist;
        win_found = 1'b1;
        win_idx   = IDX_W'(i);
        win_wren  = p_wren[i];
        win_addr  = p_address[i*ADDR_W +: ADDR_W];
      end
    end
  end

  // Next-state logic: arbitrate in IDLE, count beats in ACTIVE, drop grant after RELEASE.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    ptr_d   = ptr_q;
    req_d   = req_q;
    wren_d  = wren_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = ACTIVE;
          grant_d = N_PORTS'(1) << win_idx;
          gidx_d  = win_idx;
          req_d   = 1'b1;
          wren_d  = win_wren;
          addr_d  = win_addr;
        end
      end
      ACTIVE: begin
        if (ctrl_ready) begin
          if (cnt_q == OFS_W'(BURST_LEN - 1)) begin
            cnt_d   = '0;
            req_d   = 1'b0;
            ptr_d   = gidx_q;
            state_d = RELEASE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      RELEASE: begin
        grant_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset aborts any burst in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      ptr_q   <= IDX_W'(N_PORTS - 1);
      req_q   <= 1'b0;
      wren_q  <= 1'b0;
      addr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
      req_q   <= req_d;
      wren_q  <= wren_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Write data follows the owner's live p_to_mem with no added latency.
  always_comb begin
    ctrl_to_mem = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (grant_q[i]) ctrl_to_mem = ctrl_to_mem | p_to_mem[i*DATA_W +: DATA_W];
    end
  end

  assign p_ready      = grant_q & {N_PORTS{ctrl_ready && (state_q == ACTIVE)}};
  assign p_offset     = ctrl_offset;
  assign from_mem     = ctrl_from_mem;
  assign grant        = grant_q;
  assign busy         = (state_q != IDLE);
  assign ctrl_req     = req_q;
  assign ctrl_wren    = wren_q;
  assign ctrl_address = addr_q;

endmodule
